// File: rtl/igpu_frame_sched_if.sv
// Handshake and data bundle between the frame scheduler, its block source,
// its line sink and the igpu compress datapath.
interface igpu_frame_sched_if #(
  parameter int PIX_W = 1024
);
  logic             start;
  logic [15:0]      cfg_blocks;
  logic             busy;
  logic             frame_done;
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pixels;
  logic [PIX_W-1:0] igpu_pixels;
  logic [511:0]     igpu_lines;
  logic [1:0]       igpu_flag;
  logic             out_valid;
  logic             out_ready;
  logic [511:0]     out_lines;
  logic [1:0]       out_flag;
  logic [15:0]      out_cnt;

  modport master (
    output start, cfg_blocks, in_valid, in_pixels, igpu_lines, igpu_flag, out_ready,
    input  busy, frame_done, in_ready, igpu_pixels, out_valid, out_lines, out_flag, out_cnt
  );

  modport slave (
    input  start, cfg_blocks, in_valid, in_pixels, igpu_lines, igpu_flag, out_ready,
    output busy, frame_done, in_ready, igpu_pixels, out_valid, out_lines, out_flag, out_cnt
  );
endinterface

// File: rtl/igpu_frame_sched.sv
// Frame scheduler for the igpu compress pipeline: issues input blocks against credits
// (in-flight work plus buffered lines) and re-times pipeline results through a FIFO.

module igpu_frame_sched_chk #(
  parameter int DEPTH = 4
) (
  input logic        clk,
  input logic        rst,
  input logic        i_push,
  input logic        i_pop,
  input logic [15:0] i_occ
);
  // a push may only meet a full buffer when the head leaves on the same edge
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(i_push && !i_pop && (i_occ == 16'(DEPTH))));
endmodule

module igpu_frame_sched #(
  parameter int PIX_W = 1024,
  parameter int LAT   = 3,
  parameter int DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  igpu_frame_sched_if.slave bus
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [15:0]    r_remain;
  logic [15:0]    r_occ;
  logic [15:0]    r_out_cnt;
  logic [15:0]    w_inflight;
  logic [LAT-1:0] r_vsr;
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [511:0]   r_mem_lines [DEPTH];
  logic [1:0]     r_mem_flag  [DEPTH];
  logic           w_start_ok;
  logic           w_accept;
  logic           w_push;
  logic           w_pop;
  logic           w_drain_done;
  logic           w_in_ready;
  logic           w_out_valid;

  function automatic logic [15:0] popcount(input logic [LAT-1:0] v);
    logic [15:0] n;
    n = 16'd0;
    for (int i = 0; i < LAT; i++) begin
      n = n + 16'(v[i]);
    end
    return n;
  endfunction

  // Credits come from registered state only, so a same-cycle pop frees nothing yet.
  assign w_inflight   = popcount(r_vsr);
  assign w_push       = r_vsr[LAT-1];
  assign w_out_valid  = (r_occ != 16'd0);
  assign w_pop        = w_out_valid && bus.out_ready;
  assign w_in_ready   = (r_state == S_RUN) && (r_remain != 16'd0) &&
                        ((w_inflight + r_occ) < DEPTH_W);
  assign w_accept     = w_in_ready && bus.in_valid;
  assign w_start_ok   = bus.start && (bus.cfg_blocks != 16'd0);
  assign w_drain_done = (r_vsr == {LAT{1'b0}}) && (r_occ == 16'd0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_state_nxt = S_RUN;
        else            w_state_nxt = S_IDLE;
      end
      S_RUN: begin
        if (w_accept && (r_remain == 16'd1)) w_state_nxt = S_DRAIN;
        else                                 w_state_nxt = S_RUN;
      end
      S_DRAIN: begin
        if (w_drain_done) w_state_nxt = S_IDLE;
        else              w_state_nxt = S_DRAIN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode; an empty buffer shows zeros rather than a stale entry
  always_comb begin
    bus.busy        = (r_state != S_IDLE);
    bus.frame_done  = (r_state == S_DRAIN) && w_drain_done;
    bus.in_ready    = w_in_ready;
    bus.igpu_pixels = w_accept ? bus.in_pixels : {PIX_W{1'b0}};
    bus.out_valid   = w_out_valid;
    bus.out_cnt     = r_out_cnt;
    if (w_out_valid) begin
      bus.out_lines = r_mem_lines[r_rd_ptr];
      bus.out_flag  = r_mem_flag[r_rd_ptr];
    end else begin
      bus.out_lines = 512'd0;
      bus.out_flag  = 2'd0;
    end
  end

  // Frame counters, in-flight tracker and buffer pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_remain  <= 16'd0;
      r_vsr     <= {LAT{1'b0}};
      r_wr_ptr  <= {AW{1'b0}};
      r_rd_ptr  <= {AW{1'b0}};
      r_occ     <= 16'd0;
      r_out_cnt <= 16'd0;
    end else begin
      r_vsr <= (r_vsr << 1) | LAT'(w_accept);
      if ((r_state == S_IDLE) && w_start_ok) begin
        r_remain  <= bus.cfg_blocks;
        r_out_cnt <= 16'd0;
      end else begin
        if (w_accept) r_remain <= r_remain - 16'd1;
        if (w_pop)    r_out_cnt <= r_out_cnt + 16'd1;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1'b1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1'b1);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 16'd1;
        2'b01:   r_occ <= r_occ - 16'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Buffer storage; contents are only visible while occupancy covers them
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_lines[r_wr_ptr] <= bus.igpu_lines;
      r_mem_flag[r_wr_ptr]  <= bus.igpu_flag;
    end
  end

  igpu_frame_sched_chk #(.DEPTH(DEPTH)) u_chk (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_occ  (r_occ)
  );
endmodule

// File: tb/tb_igpu_frame_sched.sv
// Randomised bench for igpu_frame_sched: a queue-based frame/credit model and a
// registered igpu stand-in predict every output cycle by cycle.
module tb_igpu_frame_sched;
  localparam int PIX_W = 1024;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2;

  typedef struct packed { logic [511:0] lines; logic [1:0] flag; } line_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  igpu_frame_sched_if #(.PIX_W(PIX_W)) bus ();

  igpu_frame_sched #(.PIX_W(PIX_W), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic line_t xf(input logic [PIX_W-1:0] p);
    line_t r;
    r.lines = p[511:0] ^ p[1023:512];
    r.flag  = p[1023:1022] ^ p[5:4];
    return r;
  endfunction

  function automatic logic [PIX_W-1:0] rand_pix();
    logic [PIX_W-1:0] p;
    for (int i = 0; i < PIX_W / 32; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  // igpu stand-in: LAT register stages of the transform
  line_t g_pipe [LAT];
  always @(posedge clk) begin
    g_pipe[0] <= xf(bus.igpu_pixels);
    for (int i = 1; i < LAT; i++) g_pipe[i] <= g_pipe[i-1];
  end
  assign bus.igpu_lines = g_pipe[LAT-1].lines;
  assign bus.igpu_flag  = g_pipe[LAT-1].flag;

  // Reference model: frame state, in-flight items stamped with their accept cycle, buffer queue
  int    m_state, m_remain, m_cnt, cyc;
  int    m_pipe_t[$];
  line_t m_pipe_d[$];
  line_t m_buf[$];

  function automatic bit exp_in_ready();
    return (m_state == S_RUN) && (m_remain != 0) && ((m_pipe_t.size() + m_buf.size()) < DEPTH);
  endfunction
  function automatic bit exp_frame_done();
    return (m_state == S_DRAIN) && (m_pipe_t.size() == 0) && (m_buf.size() == 0);
  endfunction
  function automatic bit exp_busy();
    return m_state != S_IDLE;
  endfunction

  always @(posedge clk) begin : ref_model
    bit acc, pop, done;
    int st0;
    if (rst) begin
      m_state = S_IDLE; m_remain = 0; m_cnt = 0;
      m_pipe_t.delete(); m_pipe_d.delete(); m_buf.delete();
    end else begin
      st0  = m_state;
      acc  = exp_in_ready() && (bus.in_valid === 1'b1);
      pop  = (m_buf.size() != 0) && (bus.out_ready === 1'b1);
      done = exp_frame_done();
      if (pop) begin void'(m_buf.pop_front()); m_cnt++; end
      if (m_pipe_t.size() != 0 && (cyc - m_pipe_t[0]) == LAT) begin
        void'(m_pipe_t.pop_front());
        m_buf.push_back(m_pipe_d.pop_front());
      end
      if (acc) begin
        m_pipe_t.push_back(cyc);
        m_pipe_d.push_back(xf(bus.in_pixels));
        m_remain--;
        if (m_remain == 0) m_state = S_DRAIN;
      end
      if (done) m_state = S_IDLE;
      if (st0 == S_IDLE && bus.start === 1'b1 && bus.cfg_blocks != 16'd0) begin
        m_state = S_RUN; m_remain = int'(bus.cfg_blocks); m_cnt = 0;
      end
    end
    cyc++;
  end

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b1; bus.cfg_blocks = 16'd5; bus.in_valid = 1'b1;
    bus.in_pixels = rand_pix(); bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 2) begin
        rst = 1'b0; bus.start = 1'b0;
      end
      n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", bus.busy); end
      n_tests++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL reset frame_done: got %b want 0", bus.frame_done); end
      n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset in_ready: got %b want 0", bus.in_ready); end
      n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", bus.out_valid); end
      n_tests++; if (bus.igpu_pixels !== '0) begin n_fail++; $display("FAIL reset igpu_pixels: got nonzero want 0"); end
      n_tests++; if ({bus.out_lines, bus.out_flag} !== '0) begin n_fail++; $display("FAIL reset out_lines/flag: got %h want 0", {bus.out_lines, bus.out_flag}); end
      n_tests++; if (bus.out_cnt !== 16'd0) begin n_fail++; $display("FAIL reset out_cnt: got %0d want 0", bus.out_cnt); end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
  endtask

  task automatic test_basic();
    logic [PIX_W-1:0] pix;
    line_t            exp_l;
    pix = rand_pix(); exp_l = xf(pix);
    bus.start = 1'b1; bus.cfg_blocks = 16'd1; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_pixels = pix;
    for (int c = 0; c <= 6; c++) begin
      bus.out_ready = (c == 4);
      @(negedge clk);
      if (c == 0) begin
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic in_ready: got %b want 1", bus.in_ready); end
        n_tests++; if (bus.igpu_pixels !== pix) begin n_fail++; $display("FAIL basic igpu_pixels: not equal to in_pixels on accept"); end
      end
      if (c >= 1 && c <= 3) begin
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic early out_valid cycle %0d: got %b want 0", c, bus.out_valid); end
      end
      if (c == 4) begin
        n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic out_valid at T+4: got %b want 1", bus.out_valid); end
        n_tests++; if ({bus.out_lines, bus.out_flag} !== exp_l) begin n_fail++; $display("FAIL basic data: got %h want %h", {bus.out_lines, bus.out_flag}, exp_l); end
      end
      if (c == 5) begin
        n_tests++; if (bus.frame_done !== 1'b1) begin n_fail++; $display("FAIL basic frame_done: got %b want 1", bus.frame_done); end
        n_tests++; if (bus.out_cnt !== 16'd1) begin n_fail++; $display("FAIL basic out_cnt: got %0d want 1", bus.out_cnt); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic out_valid after pop: got %b want 0", bus.out_valid); end
      end
      if (c == 6) begin
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic busy after done: got %b want 0", bus.busy); end
        n_tests++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL basic frame_done width: got %b want 0", bus.frame_done); end
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int    acc, dones, n;
    line_t held;
    bus.start = 1'b1; bus.cfg_blocks = 16'd10;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b0; acc = 0;
    for (int c = 0; c < 12; c++) begin
      bus.in_pixels = rand_pix();
      @(negedge clk);
      n_tests++; if (bus.in_ready !== exp_in_ready()) begin n_fail++; $display("FAIL bp in_ready cycle %0d: got %b want %b", c, bus.in_ready, exp_in_ready()); end
      if (bus.in_ready === 1'b1) acc++;
      if (c == 4) held = m_buf[0];
      if (c >= 4) begin
        n_tests++; if (bus.out_valid !== 1'b1 || {bus.out_lines, bus.out_flag} !== held) begin n_fail++; $display("FAIL bp held head cycle %0d: got %b/%h want 1/%h", c, bus.out_valid, {bus.out_lines, bus.out_flag}, held); end
      end
      @(posedge clk); #1;
    end
    n_tests++; if (acc !== 4) begin n_fail++; $display("FAIL bp accepts under backpressure: got %0d want 4", acc); end
    bus.out_ready = 1'b1; dones = 0; n = 0;
    while (exp_busy() && n < 200) begin
      bus.in_pixels = rand_pix();
      @(negedge clk);
      n_tests++; if (bus.in_ready !== exp_in_ready()) begin n_fail++; $display("FAIL bp drain in_ready: got %b want %b", bus.in_ready, exp_in_ready()); end
      n_tests++; if (bus.out_valid !== (m_buf.size() != 0)) begin n_fail++; $display("FAIL bp drain out_valid: got %b want %b", bus.out_valid, m_buf.size() != 0); end
      if (m_buf.size() != 0) begin
        n_tests++; if ({bus.out_lines, bus.out_flag} !== m_buf[0]) begin n_fail++; $display("FAIL bp order: got %h want %h", {bus.out_lines, bus.out_flag}, m_buf[0]); end
      end
      if (bus.frame_done === 1'b1) dones++;
      n++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    n_tests++; if (n >= 200) begin n_fail++; $display("FAIL bp timeout: got %0d cycles want <200", n); end
    n_tests++; if (bus.out_cnt !== 16'd10) begin n_fail++; $display("FAIL bp out_cnt: got %0d want 10", bus.out_cnt); end
    n_tests++; if (dones !== 1) begin n_fail++; $display("FAIL bp frame_done pulses: got %0d want 1", dones); end
  endtask

  task automatic test_frame(input string name, input int cfg, input int in_pct, input int out_pct, input int hold);
    int n, dones;
    logic [PIX_W-1:0] exp_pix;
    bus.start = 1'b1; bus.cfg_blocks = 16'(cfg);
    @(posedge clk); #1;
    bus.start = 1'b0; n = 0; dones = 0;
    while (exp_busy() && n < 2000) begin
      bus.in_valid  = (int'($urandom_range(99)) < in_pct);
      bus.in_pixels = rand_pix();
      bus.out_ready = (n >= hold) && (int'($urandom_range(99)) < out_pct);
      @(negedge clk);
      exp_pix = (exp_in_ready() && bus.in_valid) ? bus.in_pixels : '0;
      n_tests++; if (bus.in_ready !== exp_in_ready()) begin n_fail++; $display("FAIL %s in_ready cycle %0d: got %b want %b", name, n, bus.in_ready, exp_in_ready()); end
      n_tests++; if (bus.igpu_pixels !== exp_pix) begin n_fail++; $display("FAIL %s igpu_pixels cycle %0d: mismatch with accept rule", name, n); end
      n_tests++; if (bus.out_valid !== (m_buf.size() != 0)) begin n_fail++; $display("FAIL %s out_valid cycle %0d: got %b want %b", name, n, bus.out_valid, m_buf.size() != 0); end
      if (m_buf.size() != 0) begin
        n_tests++; if ({bus.out_lines, bus.out_flag} !== m_buf[0]) begin n_fail++; $display("FAIL %s head data cycle %0d: got %h want %h", name, n, {bus.out_lines, bus.out_flag}, m_buf[0]); end
      end
      n_tests++; if (bus.frame_done !== exp_frame_done()) begin n_fail++; $display("FAIL %s frame_done cycle %0d: got %b want %b", name, n, bus.frame_done, exp_frame_done()); end
      n_tests++; if (bus.busy !== exp_busy()) begin n_fail++; $display("FAIL %s busy cycle %0d: got %b want %b", name, n, bus.busy, exp_busy()); end
      n_tests++; if (bus.out_cnt !== 16'(m_cnt)) begin n_fail++; $display("FAIL %s out_cnt cycle %0d: got %0d want %0d", name, n, bus.out_cnt, m_cnt); end
      if (bus.frame_done === 1'b1) dones++;
      n++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    n_tests++; if (n >= 2000) begin n_fail++; $display("FAIL %s timeout: got %0d cycles want <2000", name, n); end
    n_tests++; if (bus.out_cnt !== 16'(cfg)) begin n_fail++; $display("FAIL %s final out_cnt: got %0d want %0d", name, bus.out_cnt, cfg); end
    n_tests++; if (dones !== 1) begin n_fail++; $display("FAIL %s frame_done pulses: got %0d want 1", name, dones); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL %s busy after frame: got %b want 0", name, bus.busy); end
  endtask

  task automatic test_boundaries();
    int acc, n;
    bus.start = 1'b1; bus.cfg_blocks = 16'd0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL zero_cfg busy: got %b want 0", bus.busy); end
      n_tests++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL zero_cfg frame_done: got %b want 0", bus.frame_done); end
      n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL zero_cfg in_ready: got %b want 0", bus.in_ready); end
      @(posedge clk); #1;
    end
    bus.start = 1'b1; bus.cfg_blocks = 16'd3; bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.cfg_blocks = 16'd7; bus.in_valid = 1'b1;
    acc = 0; n = 0;
    while (exp_busy() && n < 100) begin
      bus.in_pixels = rand_pix();
      @(negedge clk);
      n_tests++; if (bus.in_ready !== exp_in_ready()) begin n_fail++; $display("FAIL restart in_ready: got %b want %b", bus.in_ready, exp_in_ready()); end
      if (bus.in_ready === 1'b1) acc++;
      @(posedge clk); #1;
      bus.start = 1'b0; n++;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    n_tests++; if (acc !== 3) begin n_fail++; $display("FAIL restart accepts: got %0d want 3", acc); end
    n_tests++; if (bus.out_cnt !== 16'd3) begin n_fail++; $display("FAIL restart out_cnt: got %0d want 3", bus.out_cnt); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL restart busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_reset_drain();
    bit found;
    bus.start = 1'b1; bus.cfg_blocks = 16'd3;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b0; found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      bus.in_pixels = rand_pix();
      @(negedge clk);
      if (m_state == S_DRAIN && m_buf.size() == 2 && m_pipe_t.size() == 1) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL rst_drain setup: got no drain point want 2 buffered + 1 in flight"); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_drain out_valid cycle %0d: got %b want 0", c, bus.out_valid); end
      n_tests++; if (bus.busy !== 1'b0 || bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_drain busy/done cycle %0d: got %b/%b want 0/0", c, bus.busy, bus.frame_done); end
      if (c == 0) begin
        n_tests++; if (bus.out_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_drain out_cnt: got %0d want 0", bus.out_cnt); end
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_frame("stream", 8, 100, 100, 0);
    test_frame("full_wrap", 16, 100, 100, 8);
    test_boundaries();
    test_reset_drain();
    for (int f = 0; f < 4; f++) begin
      test_frame("random", int'($urandom_range(20, 1)), int'($urandom_range(100, 30)),
                 int'($urandom_range(100, 30)), int'($urandom_range(6, 0)));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
